// File: rtl/img_mem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | img_mem_loader: streams a WIDTHxHEIGHT byte image row-major into data  |
// | memory, pulses the processor start and captures its result.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module img_mem_loader #(
  parameter int WIDTH   = 100,
  parameter int HEIGHT  = 100,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_req,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_proc_start,
  input  logic              i_proc_done,
  input  logic [31:0]       i_proc_result,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [31:0]       o_result
);

  localparam int                c_TOTAL     = WIDTH * HEIGHT;
  localparam int                c_WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_TOTAL - 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST   = c_WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [c_WD_W-1:0]   r_wd_cnt;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_proc_start;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout;
  logic [31:0]         r_result;
  logic                w_accept;
  logic                w_last;
  logic                w_launch;
  logic                w_wd_expire;

  assign o_in_ready  = (r_state == S_LOAD);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last      = w_accept && (r_addr_cnt == c_LAST_ADDR);
  assign w_launch    = i_load_req && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wd_expire = (r_wd_cnt == c_WD_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_load_req) w_next = S_LOAD;
      S_LOAD:         if (w_last) w_next = S_START;
      S_START:        w_next = S_RUN;
      S_RUN:          if (i_proc_done || w_wd_expire) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_LOAD) || (w_next == S_START) || (w_next == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_cnt   <= '0;
      r_wd_cnt     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_proc_start <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_result     <= '0;
    end else begin
      r_mem_we     <= w_accept;
      r_proc_start <= (r_state == S_START);
      if (w_accept) begin
        r_mem_addr  <= r_addr_cnt;
        r_mem_wdata <= i_in_data;
        // Counter parks on the last address so it never runs past the image.
        if (!w_last) r_addr_cnt <= r_addr_cnt + 1'b1;
      end
      if (w_launch) begin
        r_addr_cnt <= '0;
        r_done     <= 1'b0;
        r_timeout  <= 1'b0;
        r_result   <= '0;
      end
      if (r_state == S_RUN) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
        if (i_proc_done) begin
          r_result <= i_proc_result;
          r_done   <= 1'b1;
        end else if (w_wd_expire) begin
          r_timeout <= 1'b1;
          r_done    <= 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_proc_start = r_proc_start;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_timeout    = r_timeout;
  assign o_result     = r_result;

endmodule
`default_nettype wire

// File: doc/img_mem_loader.md
Name: img_mem_loader

Overview:
- Front-end for the processor's 100x100 byte image data memory: accepts a byte stream, writes it row-major into data memory, then launches the processor.
- Pulses the processor start, waits for its done, captures the 32-bit result and reports completion; a watchdog bounds the run.
- Sits between the host/stream source and `main`. It is the writer and launcher that is the counterpart of the end-of-run memory dump.

Parameters:
- WIDTH, 100, pixels per row
- HEIGHT, 100, rows
- ADDR_W, 14, memory byte-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- TIMEOUT, 1000000, maximum RUN cycles before abort

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  one-cycle request to start a new load/run
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  data-memory write enable
- mem_addr  out  ADDR_W  data-memory byte address
- mem_wdata  out  8  data-memory write byte
- proc_start  out  1  processor start pulse
- proc_done  in  1  processor done level
- proc_result  in  32  processor result
- busy  out  1  high in LOAD, START, RUN
- done  out  1  run finished (sticky)
- timeout  out  1  last run aborted by the watchdog (sticky)
- result  out  32  captured proc_result

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, including mid-load or mid-run. All outputs go to 0 and state goes to IDLE. Counters clear. Memory contents already written are not undone.
- States:
  - IDLE: load_req moves to LOAD, clears done, timeout, result and the address counter.
  - DONE: behaves as IDLE (load_req moves to LOAD, clears done, timeout, result and the address counter), but holds done=1 until then.
  - LOAD: in_ready=1 (combinational from state). Accept = in_valid & in_ready.
    - On each accept, at the next edge: mem_we<=1, mem_addr<=addr_cnt, mem_wdata<=in_data, addr_cnt<=addr_cnt+1. Write latency is 1 cycle.
    - With no accept, mem_we<=0.
    - The accept at addr_cnt==WIDTH*HEIGHT-1 is the last one; the next state is START.
  - START: mem_we carries the last write this cycle. proc_start<=1, so it is high for exactly the following single cycle. Next state is RUN.
  - RUN: proc_start<=0; watchdog counter increments each cycle.
    - If proc_done=1: result<=proc_result, done<=1, next state DONE.
    - Else if the watchdog reaches TIMEOUT-1: timeout<=1, done<=1, result unchanged (0), next state DONE.
    - If proc_done and the watchdog limit occur in the same cycle, proc_done wins and timeout stays 0.
- load_req while busy is ignored. proc_done outside RUN is ignored.
- in_ready=0 outside LOAD; bytes offered then are not consumed.
- Address is row*WIDTH+col, produced by a single incrementing counter with no wrap. The counter never exceeds WIDTH*HEIGHT-1.
- Stream gaps (in_valid=0) stall the load indefinitely; there is no timeout in LOAD.
- busy = state in {LOAD, START, RUN}, registered with the state.

Test Plan:
- WIDTH=4, HEIGHT=2, bytes 0x10..0x17 back-to-back after load_req -> 8 mem_we cycles at addresses 0..7 with data 0x10..0x17, each one cycle after its accept; proc_start is a single cycle, immediately after the address-7 write cycle.
- Same parameters, in_valid toggling 1,0,1,0 -> writes only on accepted bytes, addresses contiguous 0..7, no duplicates.
- After proc_start, hold proc_done=0 for 5 cycles, then proc_done=1 with proc_result=0xDEADBEEF -> result=0xDEADBEEF, done=1, busy=0, timeout=0 the next cycle; done stays high until the next load_req.
- TIMEOUT=20, proc_done held 0 -> done=1 and timeout=1 exactly 20 cycles after entering RUN; result=0.
- Drive rst_n=0 asynchronously after 3 accepted bytes -> all outputs 0 immediately. A new load_req after reset restarts at address 0.
- Defaults (100x100): stream 10000 bytes of value (addr mod 256), dump memory afterwards -> each of the 10000 entries equals index mod 256; load_req asserted during RUN has no effect.
